// File: rtl/aes_key_expand.sv
// AES-128/256 key schedule, one 128-bit round key per cycle via four S-box lookups.
// Optional round-key store compiled in with `define AES_KEY_STORE_EN.

module aes_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] x3, x7, x15, x31, x63, x127;
        x3   = gf_mul(gf_mul(a, a), a);
        x7   = gf_mul(gf_mul(x3, x3), a);
        x15  = gf_mul(gf_mul(x7, x7), a);
        x31  = gf_mul(gf_mul(x15, x15), a);
        x63  = gf_mul(gf_mul(x31, x31), a);
        x127 = gf_mul(gf_mul(x63, x63), a);
        return gf_mul(x127, x127);
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    assign dout = affine(gf_inv(din));
endmodule

module aes_key_expand #(
    parameter  int KEY_BITS = 128,
    localparam int NR       = (KEY_BITS == 256) ? 14 : 10,
    localparam int IDXW     = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [KEY_BITS-1:0] key_in,
    output logic                busy,
    output logic                rk_valid,
    output logic [IDXW-1:0]     rk_idx,
    output logic [127:0]        rk_out,
    output logic                done,
    input  logic [IDXW-1:0]     rd_idx,
    output logic [127:0]        rd_key,
    output logic                store_valid
);
    if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_key_expand: KEY_BITS must be 128 or 256");
    end

    localparam bit            IS256    = (KEY_BITS == 256);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NR);

    typedef enum logic {IDLE, GEN} state_t;

    state_t         state;
    logic [127:0]   ks_other;
    logic [7:0]     rcon;

    logic [IDXW-1:0] nxt_idx;
    logic            use_rot;
    logic            seed_hi;
    logic [127:0]    prev_key;
    logic [31:0]     last_w;
    logic [31:0]     sub_in;
    logic [31:0]     sub_out;
    logic [31:0]     t_w;
    logic [31:0]     n0, n1, n2, n3;
    logic [127:0]    next_key;

    function automatic logic [7:0] xtime(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction

    // For 256-bit keys ks_other holds rk(i-2); the first GEN step just emits the key's low half.
    assign nxt_idx  = rk_idx + 4'd1;
    assign use_rot  = !IS256 || !nxt_idx[0];
    assign seed_hi  = IS256 && (rk_idx == '0);
    assign prev_key = IS256 ? ks_other : rk_out;
    assign last_w   = rk_out[31:0];
    assign sub_in   = use_rot ? {last_w[23:0], last_w[31:24]} : last_w;

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .din  (sub_in[8*g +: 8]),
            .dout (sub_out[8*g +: 8])
        );
    end

    assign t_w      = sub_out ^ (use_rot ? {rcon, 24'h000000} : 32'h0);
    assign n0       = prev_key[127:96] ^ t_w;
    assign n1       = prev_key[95:64]  ^ n0;
    assign n2       = prev_key[63:32]  ^ n1;
    assign n3       = prev_key[31:0]   ^ n2;
    assign next_key = seed_hi ? ks_other : {n0, n1, n2, n3};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            rk_valid <= 1'b0;
            done     <= 1'b0;
            rk_idx   <= '0;
            rk_out   <= '0;
            rcon     <= 8'h01;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= GEN;
                        busy     <= 1'b1;
                        rk_valid <= 1'b1;
                        done     <= 1'b0;
                        rk_idx   <= '0;
                        rk_out   <= key_in[KEY_BITS-1 -: 128];
                        rcon     <= 8'h01;
                    end
                end
                GEN: begin
                    if (rk_idx == LAST_IDX) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        rk_valid <= 1'b0;
                        done     <= 1'b0;
                    end else begin
                        rk_idx <= nxt_idx;
                        rk_out <= next_key;
                        done   <= (nxt_idx == LAST_IDX);
                        if (use_rot) rcon <= xtime(rcon);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && start)
            ks_other <= key_in[127:0];
        else if (state == GEN)
            ks_other <= rk_out;
    end

`ifdef AES_KEY_STORE_EN
    logic [127:0] store [0:14];
    logic         store_vld_q;

    always_ff @(posedge clk) begin
        if (rk_valid) store[rk_idx] <= rk_out;
    end

    always_ff @(posedge clk) begin
        if (rst)
            store_vld_q <= 1'b0;
        else if (state == IDLE && start)
            store_vld_q <= 1'b0;
        else if (done)
            store_vld_q <= 1'b1;
    end

    assign store_valid = store_vld_q;
    assign rd_key      = (rd_idx <= LAST_IDX) ? store[rd_idx] : 128'h0;
`else
    logic unused_rd_idx;
    assign unused_rd_idx = ^rd_idx;
    assign store_valid   = 1'b0;
    assign rd_key        = 128'h0;
`endif
endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand: FIPS-197 vectors for 128/256-bit keys, back-to-back and reset abort.
// Store checks follow AES_KEY_STORE_EN.

module tb_aes_key_expand;
    localparam logic [127:0] FIPS128  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] RK1_128  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    localparam logic [127:0] RK2_128  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
    localparam logic [127:0] RK10_128 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] KEY_A1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] RK10_A1  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [255:0] FIPS256  =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] RK2_256  = 128'ha573c29fa176c498a97fce93a572c09c;
    localparam logic [127:0] RK3_256  = 128'h1651a8cd0244beda1a5da4c10640bade;
    localparam logic [127:0] RK14_256 = 128'h24fc79ccbf0979e9371ac23c6d68de36;

    logic         clk = 1'b0;
    logic         rst;
    logic         a_start, b_start;
    logic [127:0] a_key;
    logic [255:0] b_key;
    logic         a_busy, a_valid, a_done, a_sv;
    logic         b_busy, b_valid, b_done, b_sv;
    logic [3:0]   a_idx, b_idx, a_rd_idx, b_rd_idx;
    logic [127:0] a_rk, b_rk, a_rd_key, b_rd_key;

    int n_checks = 0;
    int n_pass   = 0;

    aes_key_expand #(.KEY_BITS(128)) dut128 (
        .clk(clk), .rst(rst), .start(a_start), .key_in(a_key),
        .busy(a_busy), .rk_valid(a_valid), .rk_idx(a_idx), .rk_out(a_rk), .done(a_done),
        .rd_idx(a_rd_idx), .rd_key(a_rd_key), .store_valid(a_sv)
    );

    aes_key_expand #(.KEY_BITS(256)) dut256 (
        .clk(clk), .rst(rst), .start(b_start), .key_in(b_key),
        .busy(b_busy), .rk_valid(b_valid), .rk_idx(b_idx), .rk_out(b_rk), .done(b_done),
        .rd_idx(b_rd_idx), .rd_key(b_rd_key), .store_valid(b_sv)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        a_start = 1'b0; b_start = 1'b0;
        a_key = '0; b_key = '0;
        a_rd_idx = '0; b_rd_idx = '0;
        tick;
        tick;
        check("rst_a_valid", 128'(a_valid), 128'(0));
        check("rst_a_busy",  128'(a_busy),  128'(0));
        check("rst_a_done",  128'(a_done),  128'(0));
        check("rst_a_idx",   128'(a_idx),   128'(0));
        check("rst_a_rk",    a_rk,          128'h0);
        check("rst_a_sv",    128'(a_sv),    128'(0));
        check("rst_b_valid", 128'(b_valid), 128'(0));
        check("rst_b_rk",    b_rk,          128'h0);
        rst = 1'b0;

        // 256-bit FIPS schedule
        b_key = FIPS256;
        b_start = 1'b1;
        tick;
        b_start = 1'b0;
        for (int k = 0; k < 17; k++) begin
            check($sformatf("b_valid%0d", k), 128'(b_valid), 128'(k <= 14));
            check($sformatf("b_busy%0d", k),  128'(b_busy),  128'(k <= 14));
            check($sformatf("b_done%0d", k),  128'(b_done),  128'(k == 14));
            if (k <= 14) check($sformatf("b_idx%0d", k), 128'(b_idx), 128'(k));
            case (k)
                0:  check("b_rk0",  b_rk, FIPS256[255:128]);
                1:  check("b_rk1",  b_rk, FIPS256[127:0]);
                2:  check("b_rk2",  b_rk, RK2_256);
                3:  check("b_rk3",  b_rk, RK3_256);
                14: check("b_rk14", b_rk, RK14_256);
                default: ;
            endcase
            tick;
        end

        // 128-bit FIPS schedule
        a_key = FIPS128;
        a_start = 1'b1;
        tick;
        a_start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            a_rd_idx = 4'(k);
            #1;
            check($sformatf("a_valid%0d", k), 128'(a_valid), 128'(k <= 10));
            check($sformatf("a_busy%0d", k),  128'(a_busy),  128'(k <= 10));
            check($sformatf("a_done%0d", k),  128'(a_done),  128'(k == 10));
            if (k <= 10) check($sformatf("a_idx%0d", k), 128'(a_idx), 128'(k));
`ifdef AES_KEY_STORE_EN
            check($sformatf("a_sv%0d", k), 128'(a_sv), 128'(k == 11));
`else
            check($sformatf("a_sv%0d", k),    128'(a_sv), 128'(0));
            check($sformatf("a_rdkey%0d", k), a_rd_key,   128'h0);
`endif
            case (k)
                0:  check("a_rk0",  a_rk, FIPS128);
                1:  check("a_rk1",  a_rk, RK1_128);
                2:  check("a_rk2",  a_rk, RK2_128);
                10: check("a_rk10", a_rk, RK10_128);
                default: ;
            endcase
            tick;
        end

`ifdef AES_KEY_STORE_EN
        a_rd_idx = 4'd10;
        #1;
        check("store_rd10", a_rd_key, RK10_128);
        a_rd_idx = 4'd0;
        #1;
        check("store_rd0", a_rd_key, FIPS128);
        a_rd_idx = 4'd12;
        #1;
        check("store_rd12", a_rd_key, 128'h0);
        check("store_valid_after", 128'(a_sv), 128'(1));
`endif

        // start held high; key_in changes mid-schedule
        a_key = FIPS128;
        a_start = 1'b1;
        tick;
        check("held_valid0", 128'(a_valid), 128'(1));
        check("held_idx0",   128'(a_idx),   128'(0));
`ifdef AES_KEY_STORE_EN
        check("store_cleared", 128'(a_sv), 128'(0));
`endif
        a_key = '1;
        for (int k = 1; k <= 10; k++) tick;
        check("held_idx10",  128'(a_idx),  128'(10));
        check("held_rk10",   a_rk,         RK10_128);
        check("held_done10", 128'(a_done), 128'(1));
        tick;
        check("gap_valid", 128'(a_valid), 128'(0));
        check("gap_busy",  128'(a_busy),  128'(0));
        check("gap_done",  128'(a_done),  128'(0));
        tick;
        check("restart_valid", 128'(a_valid), 128'(1));
        check("restart_idx",   128'(a_idx),   128'(0));
        check("restart_rk0",   a_rk,          {128{1'b1}});
        a_start = 1'b0;

        // reset abort at round 5, then rst/start collision, then clean start
        for (int k = 1; k <= 5; k++) tick;
        check("abort_idx5", 128'(a_idx), 128'(5));
        rst = 1'b1;
        tick;
        check("abort_valid", 128'(a_valid), 128'(0));
        check("abort_busy",  128'(a_busy),  128'(0));
        check("abort_idx",   128'(a_idx),   128'(0));
        check("abort_rk",    a_rk,          128'h0);
        a_key = KEY_A1;
        a_start = 1'b1;
        tick;
        check("rst_prio_valid", 128'(a_valid), 128'(0));
        rst = 1'b0;
        tick;
        check("post_rst_valid", 128'(a_valid), 128'(1));
        check("post_rst_idx",   128'(a_idx),   128'(0));
        check("post_rst_rk0",   a_rk,          KEY_A1);
        a_start = 1'b0;
        for (int k = 1; k <= 10; k++) tick;
        check("a1_rk10",   a_rk,          RK10_A1);
        check("a1_done10", 128'(a_done), 128'(1));
        tick;
        check("a1_end_valid", 128'(a_valid), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/aes_key_expand.md
AES_KEY_EXPAND -- requirements
Module: aes_key_expand

Interface
REQ-001 Parameter: KEY_BITS, 128, cipher key length; legal values 128 or 256, anything else is an elaboration error.
REQ-002 Derived: NR = 10 for KEY_BITS=128, NR = 14 for KEY_BITS=256; IDXW = 4.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request a new key schedule; sampled only in IDLE.
REQ-006 key_in  input  KEY_BITS  cipher key, byte 0 at MSB; sampled on the start-accept edge.
REQ-007 busy  output  1  high while state is GEN.
REQ-008 rk_valid  output  1  rk_out/rk_idx carry a valid round key this cycle.
REQ-009 rk_idx  output  IDXW  round number of rk_out, 0..NR.
REQ-010 rk_out  output  128  round key, word w[4*rk_idx] at MSB.
REQ-011 done  output  1  single-cycle pulse coincident with rk_idx==NR.
REQ-012 rd_idx  input  IDXW  stored-key read address (see Configuration).
REQ-013 rd_key  output  128  stored round key at rd_idx.
REQ-014 store_valid  output  1  key store holds a complete schedule.

Function
REQ-015 FSM states IDLE, GEN; IDLE->GEN on start=1; GEN->IDLE on the edge that emits rk_idx==NR; no other transitions except reset.
REQ-016 start while in GEN is ignored; key_in changes during GEN have no effect.
REQ-017 All outputs except rd_key are registered.
REQ-018 Latency: round key 0 is valid the cycle after the start-accept edge; round key i is valid i cycles later; exactly NR+1 consecutive rk_valid cycles, no gaps.
REQ-019 busy == rk_valid on every cycle.
REQ-020 Generation is FIPS-197 key expansion producing 4 words (128 bits) per cycle, using 4 instances of the team's existing S-box module (one SubWord per cycle).
REQ-021 KEY_BITS=128: rk0 = key_in; rk(i) derived from rk(i-1) with RotWord+SubWord+Rcon on the first word.
REQ-022 KEY_BITS=256: rk0 = key_in[255:128], rk1 = key_in[127:0]; even rounds i>=2 use RotWord+SubWord+Rcon on the first word; odd rounds i>=3 use SubWord only (no rotation, no Rcon).
REQ-023 Rcon held in an 8-bit register, loaded with 0x01 on start accept and advanced by GF(2^8) xtime (0x80 -> 0x1B) after each use; sequence 01,02,04,08,10,20,40,80,1B,36.
REQ-024 Back-to-back: start=1 on the cycle done=1 is not accepted (state still GEN at that edge); start is accepted on the following cycle at the earliest.
REQ-025 done is never high when rk_valid is low.

Reset
REQ-026 On rst=1 at a clock edge: state=IDLE, busy=0, rk_valid=0, done=0, rk_idx=0, rk_out=0, Rcon=0x01, store_valid=0.
REQ-027 rst during GEN aborts the schedule; no further rk_valid; start is accepted on the first edge where rst=0.
REQ-028 rst has priority over start on the same edge.

Configuration
REQ-029 Macro AES_KEY_STORE_EN compiled in: internal 15x128 register file; each emitted round key is written at index rk_idx; rd_key = store[rd_idx] combinationally; store_valid set on the done edge, cleared on start accept and on reset; rd_idx > NR returns 0.
REQ-030 AES_KEY_STORE_EN not defined: no storage inferred; rd_key tied to 0; store_valid tied to 0; rd_idx ignored; ports remain present.

Verification
REQ-031 KEY_BITS=128, key 000102030405060708090a0b0c0d0e0f, start pulse -> 11 rk_valid cycles; rk_idx=1 rk_out=d6aa74fdd2af72fadaa678f1d6ab76fe; rk_idx=10 rk_out=13111d7fe3944a17f307a78b4d2b30c5 with done=1.
REQ-032 KEY_BITS=256, key 000102...1e1f -> 15 rk_valid cycles; rk_idx=2 rk_out=a573c29fa176c498a97fce93a572c09c; rk_idx=14 rk_out=24fc79ccbf0979e9371ac23c6d68de36 with done=1.
REQ-033 start held high continuously, KEY_BITS=128 -> schedules of 11 valid cycles separated by exactly one idle cycle; second start's key_in change mid-GEN has no effect on the running schedule.
REQ-034 rst=1 asserted at rk_idx=5 -> rk_valid=0, busy=0 next cycle; new start one cycle later yields rk0 = new key_in.
REQ-035 AES_KEY_STORE_EN defined, KEY_BITS=128 FIPS key -> after done, store_valid=1; rd_idx=10 gives 13111d7fe3944a17f307a78b4d2b30c5; rd_idx=0 gives 000102...0f; rd_idx=12 gives 0; new start clears store_valid.
REQ-036 AES_KEY_STORE_EN undefined -> rd_key=0 and store_valid=0 throughout REQ-031 stimulus.
